// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: holds the PC, issues one imem read at a time, and buffers {pc, instr} for decode.
// Latency: a request issues one cycle after a word is accepted; the word reaches id_* the cycle after imem_rvalid.
// Backpressure: id_ready low fills the buffer, which stops requests. Optional perf counters via FETCH_PERF_EN.

// fetch_fifo: small synchronous FIFO with flush and a combinational head.
// Latency: a pushed word is visible at the head on the next cycle.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fetch_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module fetch_stage #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     perf_fetched,
    output logic [15:0]     perf_flushes
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;
    localparam int         CW     = $clog2(DEPTH) + 1;
    localparam int         EW     = PC_W + 32;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_out_en;

    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic            w_id_valid;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;

    // r_out_en holds off the first request until one edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
        end
    end

    assign w_id_valid = (w_count != '0);
    // The in-flight word's slot is reserved: only IDLE may issue, so count+inflight <= DEPTH.
    assign w_issue    = r_out_en && (r_state == S_IDLE) && !redirect && (w_count < CW'(DEPTH));
    assign w_push     = (r_state == S_WAIT) && imem_rvalid && !redirect;
    assign w_pop      = w_id_valid && id_ready && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_push) begin
                r_pc <= r_pc + PC_W'(4);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_IDLE;
                    end else if (redirect) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .i_rst_n    (reset),
        .i_flush    (redirect),
        .i_push     (w_push),
        .i_push_dat ({r_pc, imem_rdata}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign id_valid  = w_id_valid;
    // Stale storage stays hidden while the buffer is empty.
    assign id_pc     = w_id_valid ? w_head[EW-1:32] : '0;
    assign id_instr  = w_id_valid ? w_head[31:0]    : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [15:0] r_perf_flushes;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (redirect) begin
                r_perf_flushes <= r_perf_flushes + 16'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_fetched = '0;
    assign perf_flushes = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected requests and deliveries are queued by the stimulus and
// popped by monitors on imem_req and on each id handshake; a simple latency-programmable imem model responds.
module tb_fetch_stage;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } dat_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushes;

    int   n_cmp = 0;
    int   n_err = 0;
    int   lat = 1;
    int   exp_flush = 0;
    int   n_deliv = 0;
    int   fetched_base = 0;
    logic [63:0] exp_req [$];
    dat_t        exp_dat [$];

    fetch_stage #(
        .PC_W     (64),
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .perf_fetched (perf_fetched),
        .perf_flushes (perf_flushes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hF840_0000 + a[31:0];
    endfunction

    // imem model: samples a request mid-cycle, answers lat cycles later with a one-cycle rvalid.
    initial begin
        logic        seen;
        logic [63:0] a;
        logic [63:0] paddr;
        logic        pend;
        int          cnt;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend  = 1'b0;
        cnt   = 0;
        paddr = 64'h0;
        forever begin
            @(negedge clk);
            seen = imem_req;
            a    = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (seen === 1'b1) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = a;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
                end else begin
                    check64("req_addr", imem_addr, exp_req.pop_front());
                end
            end
        end
    end

    initial begin
        dat_t e;
        forever begin
            @(negedge clk);
            if (id_valid === 1'b1 && id_ready && !redirect) begin
                n_deliv++;
                if (exp_dat.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL deliv_unexpected: got pc %h expected no delivery", id_pc);
                end else begin
                    e = exp_dat.pop_front();
                    check64("deliv_pc", id_pc, e.pc);
                    check64("deliv_instr", 64'(id_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_pulse();
        tick(1);
        id_ready = 1'b1;
        tick(1);
        id_ready = 1'b0;
    endtask

    task automatic wait_req(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = imem_req;
        end
        check64(name, 64'(found), 64'd1);
    endtask

    task automatic check_quiet(input string name);
        logic any;
        any = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any = any | imem_req;
        end
        check64(name, 64'(any), 64'd0);
    endtask

    task automatic check_head(input string name, input logic [63:0] pc, input logic [31:0] instr);
        check64({name, "_valid"}, 64'(id_valid), 64'd1);
        check64({name, "_pc"}, id_pc, pc);
        check64({name, "_instr"}, 64'(id_instr), 64'(instr));
    endtask

    task automatic check_perf(input string name);
`ifdef FETCH_PERF_EN
        check64({name, "_fetched"}, 64'(perf_fetched), 64'(32'(n_deliv - fetched_base)));
        check64({name, "_flushes"}, 64'(perf_flushes), 64'(16'(exp_flush)));
`else
        check64({name, "_fetched"}, 64'(perf_fetched), 64'd0);
        check64({name, "_flushes"}, 64'(perf_flushes), 64'd0);
`endif
    endtask

    task automatic check_zero(input string name);
        check64({name, "_req"}, 64'(imem_req), 64'd0);
        check64({name, "_valid"}, 64'(id_valid), 64'd0);
        check64({name, "_instr"}, 64'(id_instr), 64'd0);
        check64({name, "_pc"}, id_pc, 64'd0);
        check_perf(name);
    endtask

    initial begin
        reset       = 1'b1;
        id_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #1 reset = 1'b0;
        #3 check_zero("reset");
        tick(2);
        reset = 1'b1;

        // Fill with id_ready low, then single pops.
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        exp_req.push_back(64'h8);
        exp_req.push_back(64'hC);
        exp_dat.push_back('{pc: 64'h0, instr: 32'hF840_0000});
        exp_dat.push_back('{pc: 64'h4, instr: 32'hF840_0004});
        tick(12);
        check_quiet("full_no_req");
        tick(1);
        check_head("full_head", 64'h0, 32'hF840_0000);
        pop_pulse();
        tick(6);
        check_head("pop1_head", 64'h4, 32'hF840_0004);
        pop_pulse();
        tick(8);
        check_head("pop2_head", 64'h8, 32'hF840_0008);
        check_perf("p1");

        // Redirect while WAIT, before the response.
        lat = 3;
        exp_req.push_back(64'h10);
        exp_req.push_back(64'h100);
        exp_req.push_back(64'h104);
        exp_dat.push_back('{pc: 64'h8, instr: 32'hF840_0008});
        pop_pulse();
        wait_req("p2_req_seen");
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        exp_flush++;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        check64("p2_valid_after_redirect", 64'(id_valid), 64'd0);
        tick(25);
        check_head("p2_head", 64'h100, 32'hF840_0100);
        check_perf("p2");

        // Redirect coincident with rvalid and an offered handshake.
        exp_req.push_back(64'h108);
        exp_req.push_back(64'h40);
        exp_req.push_back(64'h44);
        exp_dat.push_back('{pc: 64'h100, instr: 32'hF840_0100});
        pop_pulse();
        wait_req("p3_req_seen");
        tick(3);
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        id_ready    = 1'b1;
        exp_flush++;
        tick(1);
        redirect = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        check64("p3_valid_after_redirect", 64'(id_valid), 64'd0);
        tick(25);
        check_head("p3_head", 64'h40, 32'hF840_0040);
        check_perf("p3");

        // PC wrap from the top of the address space; push and pop in one cycle.
        lat = 1;
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        exp_req.push_back(64'h8);
        exp_dat.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, instr: 32'hF83F_FFFC});
        exp_dat.push_back('{pc: 64'h0, instr: 32'hF840_0000});
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_flush++;
        tick(1);
        redirect = 1'b0;
        @(negedge clk);
        check64("p4_valid_after_redirect", 64'(id_valid), 64'd0);
        tick(10);
        check_head("wrap_head", 64'hFFFF_FFFF_FFFF_FFFC, 32'hF83F_FFFC);
        pop_pulse();
        pop_pulse();
        tick(8);
        check_head("wrap_after", 64'h4, 32'hF840_0004);
        check_perf("p4");

        // Asynchronous reset mid-WAIT; the late response lands in IDLE.
        lat = 3;
        exp_req.push_back(64'hC);
        exp_req.push_back(64'h0);
        exp_req.push_back(64'h4);
        exp_req.push_back(64'h8);
        exp_req.push_back(64'hC);
        exp_dat.push_back('{pc: 64'h4, instr: 32'hF840_0004});
        exp_dat.push_back('{pc: 64'h0, instr: 32'hF840_0000});
        exp_dat.push_back('{pc: 64'h4, instr: 32'hF840_0004});
        pop_pulse();
        wait_req("p5_req_seen");
        tick(1);
        #2;
        reset        = 1'b0;
        exp_flush    = 0;
        fetched_base = n_deliv;
        #1;
        check_zero("async_reset");
        tick(1);
        reset = 1'b1;
        tick(20);
        check_head("p5_head", 64'h0, 32'hF840_0000);
        pop_pulse();
        pop_pulse();
        tick(25);
        check_head("p5_final", 64'h8, 32'hF840_0008);
        check_perf("p5");
        check64("req_queue_left", 64'(exp_req.size()), 64'd0);
        check64("dat_queue_left", 64'(exp_dat.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
